// File: rtl/start_window_checker.sv
// start_window_checker: opens a WINDOW-sample check window on arm and reports pass/fail on start.
// Build option START_WIN_STATS_EN adds saturating pass/fail event counters; otherwise they read 0.
module start_window_checker #(
    parameter int WINDOW = 20,
    parameter int CNT_W  = 5,
    parameter int STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              start,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [CNT_W-1:0]  latency,
    output logic [STAT_W-1:0] pass_cnt,
    output logic [STAT_W-1:0] fail_cnt
);

    // state | meaning
    // IDLE  | no window open; arm opens one (start ignored on that edge)
    // ARMED | window open; start sampled on each edge 1..WINDOW
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] WIN_TC  = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] latency_q, latency_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    assign cnt_inc = cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            latency_q <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            latency_q <= latency_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
        end
    end

    // Start wins over expiry on the last sample, so pass and fail are exclusive.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latency_d = latency_q;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
            end
            ARMED: begin
                cnt_d = cnt_inc;
                if (start) begin
                    pass_d    = 1'b1;
                    latency_d = cnt_inc;
                    state_d   = IDLE;
                end else if (cnt_inc == WIN_TC) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q == ARMED);
    assign pass    = pass_q;
    assign fail    = fail_q;
    assign latency = latency_q;

`ifdef START_WIN_STATS_EN
    logic [STAT_W-1:0] pass_cnt_q, fail_cnt_q;

    // Counters move on the same edge that launches the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            if (pass_d && (pass_cnt_q != '1))
                pass_cnt_q <= pass_cnt_q + STAT_W'(1);
            if (fail_d && (fail_cnt_q != '1))
                fail_cnt_q <= fail_cnt_q + STAT_W'(1);
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
`else
    assign pass_cnt = '0;
    assign fail_cnt = '0;
`endif

endmodule
